// File: rtl/braille_pkg.sv
// Shared types and helpers for the Braille dot driver: FSM state encoding,
// the 26-letter dot pattern table and ASCII letter classification helpers.
package braille_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } braille_st_t;

  // Bit k of each entry drives Braille dot k+1; entry 0 is 'a'.
  localparam logic [5:0] BRAILLE_PATTERNS [26] = '{
    6'b000001, 6'b000011, 6'b001001, 6'b011001, 6'b010001,  // a-e
    6'b001011, 6'b011011, 6'b010011, 6'b001010, 6'b011010,  // f-j
    6'b000101, 6'b000111, 6'b001101, 6'b011101, 6'b010101,  // k-o
    6'b001111, 6'b011111, 6'b010111, 6'b001110, 6'b011110,  // p-t
    6'b100101, 6'b100111, 6'b111010, 6'b101101, 6'b111101,  // u-y
    6'b110101                                               // z
  };

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ? (c + 8'h20) : c;
  endfunction

  // Expects a lowercase letter; anything else yields a blank cell.
  function automatic logic [5:0] letter_pattern(input logic [7:0] c);
    logic [4:0] idx;
    idx = 5'(c - 8'h61);
    if ((c >= 8'h61) && (c <= 8'h7A)) begin
      return BRAILLE_PATTERNS[idx];
    end
    return 6'b000000;
  endfunction

endpackage

// File: rtl/braille_char_fifo.sv
// Small character FIFO with first-word-fall-through output. A push is
// accepted while full when a pop happens in the same cycle.
module braille_char_fifo
  import braille_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop_eff;
  logic          push_eff;

  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign dout     = mem[rd_ptr_reg];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/braille_dot_driver.sv
// Braille dot driver: filters classifier letters into a FIFO, then shows
// each as a 6-dot cell for HOLD_CYCLES followed by a GAP_CYCLES blank.
module braille_dot_driver
  import braille_pkg::*;
#(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 20_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_alpha,
  output logic [5:0] o_dots,
  output logic       o_dots_valid,
  output logic [7:0] o_char,
  output logic       o_char_done,
  output logic       o_busy,
  output logic       o_overflow,
  output logic       o_bad_char
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  braille_st_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       dots_reg, dots_next;
  logic [7:0]       char_reg, char_next;
  logic             dots_valid_reg, dots_valid_next;
  logic             char_done_reg, char_done_next;
  logic             overflow_reg, bad_char_reg;

  logic             letter;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;

  assign letter    = is_letter(i_alpha);
  assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;
  assign fifo_push = i_valid && letter && (!fifo_full || fifo_pop);

  braille_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (to_lower(i_alpha)),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State, counter and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      dots_reg       <= '0;
      char_reg       <= '0;
      dots_valid_reg <= 1'b0;
      char_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      dots_reg       <= dots_next;
      char_reg       <= char_next;
      dots_valid_reg <= dots_valid_next;
      char_done_reg  <= char_done_next;
    end
  end

  // Next-state and next-output logic for the IDLE/SHOW/GAP sequence.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    dots_next       = dots_reg;
    char_next       = char_reg;
    dots_valid_next = dots_valid_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          dots_next       = letter_pattern(fifo_dout);
          char_next       = fifo_dout;
          dots_valid_next = 1'b1;
          cnt_next        = '0;
          state_next      = SHOW;
        end
      end
      SHOW: begin
        if (cnt_reg == HOLD_LAST) begin
          dots_next       = '0;
          char_next       = '0;
          dots_valid_next = 1'b0;
          cnt_next        = '0;
          state_next      = GAP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Registered pulse must land in the final GAP cycle, so raise it when
    // the upcoming cycle is that one.
    char_done_next = (state_next == GAP) && (cnt_next == GAP_LAST);
  end

  // Sticky error flags for dropped letters and non-letter codes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_reg <= 1'b0;
      bad_char_reg <= 1'b0;
    end else begin
      if (i_valid && letter && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
      if (i_valid && !letter) bad_char_reg <= 1'b1;
    end
  end

  assign o_dots       = dots_reg;
  assign o_dots_valid = dots_valid_reg;
  assign o_char       = char_reg;
  assign o_char_done  = char_done_reg;
  assign o_busy       = (state_reg != IDLE) || !fifo_empty;
  assign o_overflow   = overflow_reg;
  assign o_bad_char   = bad_char_reg;

endmodule

// File: tb/tb_braille_dot_driver.sv
// Self-checking bench for braille_dot_driver using a timeline-based
// reference: each cell occupies HOLD+GAP+1 cycles from its pop edge.
module tb_braille_dot_driver;

  localparam int H = 8;
  localparam int G = 3;
  localparam int DEPTH = 4;
  localparam logic [5:0] BASE [10] = '{
    6'b000001, 6'b000011, 6'b001001, 6'b011001, 6'b010001,
    6'b001011, 6'b011011, 6'b010011, 6'b001010, 6'b011010
  };

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_alpha = 8'h00;
  logic [5:0] o_dots;
  logic       o_dots_valid;
  logic [7:0] o_char;
  logic       o_char_done;
  logic       o_busy;
  logic       o_overflow;
  logic       o_bad_char;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] cur = 8'h00;
  bit         active = 0;
  int         start = 0;
  int         t = 0;
  bit         ovf = 0;
  bit         bad = 0;

  braille_dot_driver #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (i_valid),
    .i_alpha      (i_alpha),
    .o_dots       (o_dots),
    .o_dots_valid (o_dots_valid),
    .o_char       (o_char),
    .o_char_done  (o_char_done),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_bad_char   (o_bad_char)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_pattern(input logic [7:0] c);
    int idx;
    int k;
    idx = int'(c) - 97;
    if (idx < 10) return BASE[idx];
    if (idx < 20) return BASE[idx-10] | 6'b000100;
    if (c == 8'h77) return 6'b111010;
    k = (c == 8'h75) ? 0 : (c == 8'h76) ? 1 : (idx - 23 + 2);
    return BASE[k] | 6'b100100;
  endfunction

  function automatic bit ref_is_letter(input logic [7:0] c);
    return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, t);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare all outputs.
  task automatic step(input bit v, input logic [7:0] a, input bit rst);
    bit in_show;
    bit in_cell;
    bit done;
    @(negedge clk);
    i_valid = v;
    i_alpha = a;
    reset_n = !rst;
    @(posedge clk);
    t++;
    if (rst) begin
      q.delete();
      active = 0;
      ovf = 0;
      bad = 0;
    end else begin
      if ((!active || t >= start + H + G + 1) && q.size() > 0) begin
        cur = q.pop_front();
        start = t;
        active = 1;
      end
      if (v) begin
        if (ref_is_letter(a)) begin
          if (q.size() < DEPTH) q.push_back((a <= 8'd90) ? a + 8'd32 : a);
          else ovf = 1;
        end else begin
          bad = 1;
        end
      end
    end
    #1;
    in_show = active && (t - start) < H;
    in_cell = active && (t - start) < H + G;
    done    = active && (t - start) == H + G - 1;
    check("dots",       {2'b00, o_dots}, in_show ? {2'b00, ref_pattern(cur)} : 8'h00);
    check("char",       o_char, in_show ? cur : 8'h00);
    check("dots_valid", {7'd0, o_dots_valid}, {7'd0, in_show});
    check("char_done",  {7'd0, o_char_done}, {7'd0, done});
    check("busy",       {7'd0, o_busy}, {7'd0, (q.size() > 0) || in_cell});
    check("overflow",   {7'd0, o_overflow}, {7'd0, ovf});
    check("bad_char",   {7'd0, o_bad_char}, {7'd0, bad});
    $display("cycle %0d v=%0b a=%02h rst=%0b -> dots=%06b char=%02h dv=%0b done=%0b busy=%0b ovf=%0b bad=%0b",
             t, v, a, rst, o_dots, o_char, o_dots_valid, o_char_done, o_busy, o_overflow, o_bad_char);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  initial begin
    // reset
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    // single 'a'
    step(1, 8'h61, 0);
    idle(16);

    // 'Z' folds to 'z', then 'w' and 'k'
    step(1, 8'h5A, 0);
    idle(14);
    step(1, 8'h77, 0);
    idle(14);
    step(1, 8'h6B, 0);
    idle(14);

    // sweep every letter, alternating case
    for (int i = 0; i < 26; i++) begin
      step(1, (i % 2 == 0) ? 8'(8'h61 + i) : 8'(8'h41 + i), 0);
      idle(12);
    end

    // six back-to-back strobes: a..e shown, f dropped
    for (int i = 0; i < 6; i++) step(1, 8'(8'h61 + i), 0);
    idle(64);

    // non-letter: no display, sticky flag
    step(1, 8'h31, 0);
    idle(5);

    // reset mid-SHOW of 'c', then 'b' displays normally
    step(1, 8'h63, 0);
    idle(5);
    step(0, 8'h00, 1);
    idle(2);
    step(1, 8'h62, 0);
    idle(14);

    // strobe during GAP is queued and shown after char_done
    step(1, 8'h64, 0);
    idle(10);
    step(1, 8'h65, 0);
    idle(24);

    // randomized traffic with occasional junk codes and resets
    for (int i = 0; i < 400; i++) begin
      bit v;
      logic [7:0] a;
      int r;
      v = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      if (r == 0) a = 8'($urandom_range(0, 255));
      else if (r < 5) a = 8'(8'h41 + $urandom_range(0, 25));
      else a = 8'(8'h61 + $urandom_range(0, 25));
      step(v, a, $urandom_range(0, 199) == 0);
    end
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
